cache_l2_control: RTL

CACHE_L2_CONTROL -- requirements
Module: cache_l2_control

---
 rtl/cache_l2_control.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cache_l2_control.sv
// L2 cache controller: sequences tag check, dirty-victim writeback, line fetch and fill,
// and keeps saturating hit/miss/writeback performance counters.
module cache_l2_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  // Upstream request interface
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,

  // Datapath status
  input  logic                 hit,
  input  logic                 eviction,

  // Physical memory interface
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,

  // Datapath enables and mux selects
  output logic                 array_read,
  output logic                 array_load,
  output logic                 lru_load,
  output logic                 pmdr_load,
  output logic                 dirty_load,
  output logic                 datawritemux_sel,
  output logic                 adaptermux_sel,
  output logic                 pmemaddrmux_sel,

  // Performance counters
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWriteback,
    StFetch,
    StFill
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e               state_q, state_d;
  // Set while the CHECK being visited is the re-check that follows a FILL.
  logic                 refill_q, refill_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

  logic is_write;
  logic hit_evt;
  logic miss_evt;
  logic wb_evt;

  // Simultaneous read and write strobes are serviced as a write.
  assign is_write = mem_write;

  // Next state and per-state outputs
  always_comb begin
    state_d          = state_q;
    refill_d         = refill_q;
    hit_evt          = 1'b0;
    miss_evt         = 1'b0;
    wb_evt           = 1'b0;
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    array_read       = 1'b0;
    array_load       = 1'b0;
    lru_load         = 1'b0;
    pmdr_load        = 1'b0;
    dirty_load       = 1'b0;
    datawritemux_sel = 1'b0;
    adaptermux_sel   = 1'b0;
    pmemaddrmux_sel  = 1'b0;

    case (state_q)
      StIdle: begin
        array_read = 1'b1;
        refill_d   = 1'b0;
        if (mem_read || mem_write) begin
          state_d = StCheck;
        end
      end

      StCheck: begin
        refill_d = 1'b0;
        if (hit) begin
          array_read = 1'b1;
          lru_load   = 1'b1;
          mem_resp   = 1'b1;
          if (is_write) begin
            array_load       = 1'b1;
            datawritemux_sel = 1'b1;
            dirty_load       = 1'b1;
          end
          hit_evt = ~refill_q;
          state_d = StIdle;
        end else begin
          miss_evt = 1'b1;
          if (eviction) begin
            state_d = StWriteback;
          end else if (is_write) begin
            // A write miss replaces the whole line, so nothing is fetched.
            state_d = StFill;
          end else begin
            state_d = StFetch;
          end
        end
      end

      StWriteback: begin
        pmem_write      = 1'b1;
        pmemaddrmux_sel = 1'b1;
        if (pmem_resp) begin
          wb_evt  = 1'b1;
          state_d = is_write ? StFill : StFetch;
        end
      end

      StFetch: begin
        pmem_read = 1'b1;
        pmdr_load = pmem_resp;
        if (pmem_resp) begin
          state_d = StFill;
        end
      end

      StFill: begin
        array_load       = 1'b1;
        dirty_load       = 1'b1;
        datawritemux_sel = is_write;
        refill_d         = 1'b1;
        state_d          = StCheck;
      end

      default: begin
        state_d  = StIdle;
        refill_d = 1'b0;
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_evt && (hit_cnt_q != CntMax)) begin
      hit_cnt_d = hit_cnt_q + CntOne;
    end
    if (miss_evt && (miss_cnt_q != CntMax)) begin
      miss_cnt_d = miss_cnt_q + CntOne;
    end
    if (wb_evt && (wb_cnt_q != CntMax)) begin
      wb_cnt_d = wb_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;

endmodule
